// File: rtl/data_mem_responder.sv
// data_mem_responder
//
// Memory-side responder for load/store requests from the pipeline memory
// stage. It owns a 2**DEPTH_LOG2 x DATA_W data array. It accepts one request
// at a time, spends WAIT_STATES cycles in WAIT, and then returns a
// single-cycle response. This lets the memory stage run against realistic
// multi-cycle latency.
//
// Handshake:
//   A request transfers on a rising edge where req_valid && req_ready.
//   req_ready is high only in IDLE. The requester keeps req_valid and the
//   req_* fields steady until that edge. After the transfer, req_* are
//   ignored until the next IDLE cycle. resp_valid is a one-cycle pulse with
//   no backpressure. resp_rdata and resp_err are meaningful only while
//   resp_valid is high, and they read 0 at all other times.
//
// Ports:
//   clk         single clock, rising edge
//   reset       synchronous active-low reset
//   req_valid   request present
//   req_ready   responder can accept a request this cycle
//   req_write   1 = store, 0 = load
//   req_addr    word address (ADDR_W bits)
//   req_wdata   store data (DATA_W bits)
//   resp_valid  response pulse, exactly one cycle
//   resp_rdata  load data; 0 for stores and out-of-range accesses
//   resp_err    address beyond the implemented depth
//   busy        high in WAIT and RESP

module data_mem_responder #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int DEPTH_LOG2  = 12,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  // Value loaded into the counter on acceptance. The counter then takes
  // WAIT_STATES cycles to reach 0. It is unused when WAIT_STATES is 0.
  localparam logic [3:0] WAIT_INIT =
    (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            state;
  logic [3:0]        wait_cnt;
  logic              lat_write;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  logic [DATA_W-1:0] mem [DEPTH];

  // Commit path signals
  logic                  accept;
  logic                  enter_resp;
  logic                  cmt_write;
  logic [ADDR_W-1:0]     cmt_addr;
  logic [DATA_W-1:0]     cmt_wdata;
  logic                  cmt_in_range;
  logic [DEPTH_LOG2-1:0] cmt_idx;
  logic                  do_store;
  logic [DATA_W-1:0]     rdata_next;

  always_comb begin
    accept     = 1'b0;
    enter_resp = 1'b0;
    cmt_write  = lat_write;
    cmt_addr   = lat_addr;
    cmt_wdata  = lat_wdata;

    accept = (state == ST_IDLE) && req_valid;

    // The RESP-entry edge comes either from WAIT when the counter expires,
    // or straight from IDLE in a zero-wait build.
    enter_resp = ((state == ST_WAIT) && (wait_cnt == 4'd0)) ||
                 (accept && (WAIT_STATES == 0));

    // In a zero-wait build the commit happens on the acceptance edge itself.
    // At that point the request is still on the inputs, not in the latches.
    if (state == ST_IDLE) begin
      cmt_write = req_write;
      cmt_addr  = req_addr;
      cmt_wdata = req_wdata;
    end
  end

  // The access is in range only when every bit above the implemented index
  // is zero, so high addresses never alias onto low words.
  assign cmt_in_range = ((cmt_addr >> DEPTH_LOG2) == '0);
  assign cmt_idx      = cmt_addr[DEPTH_LOG2-1:0];

  // The write is gated by reset. A store aborted by reset is never written.
  assign do_store     = reset && enter_resp && cmt_write && cmt_in_range;

  assign rdata_next   = (!cmt_write && cmt_in_range) ? mem[cmt_idx] : '0;

  // The data array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (do_store) begin
      mem[cmt_idx] <= cmt_wdata;
    end
  end

  // Control FSM. All outputs are registered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      wait_cnt   <= 4'd0;
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (enter_resp) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_rdata <= rdata_next;
              resp_err   <= !cmt_in_range;
            end else begin
              state    <= ST_WAIT;
              wait_cnt <= WAIT_INIT;
            end
          end
        end

        ST_WAIT: begin
          if (enter_resp) begin
            state      <= ST_RESP;
            resp_valid <= 1'b1;
            resp_rdata <= rdata_next;
            resp_err   <= !cmt_in_range;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end

        ST_RESP: begin
          // A request offered during RESP is not taken here. It is taken in
          // the IDLE cycle that follows, provided the requester still holds it.
          state      <= ST_IDLE;
          resp_valid <= 1'b0;
          resp_rdata <= '0;
          resp_err   <= 1'b0;
          req_ready  <= 1'b1;
          busy       <= 1'b0;
        end

        default: begin
          state      <= ST_IDLE;
          resp_valid <= 1'b0;
          resp_rdata <= '0;
          resp_err   <= 1'b0;
          req_ready  <= 1'b1;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder.
// Two instances are used: dut_a with WAIT_STATES=2 and dut_b with
// WAIT_STATES=0. Cycle numbering starts at the acceptance cycle, which is
// cycle 0.

module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset;

  logic        a_valid, a_write;
  logic [15:0] a_addr, a_wdata;
  logic        a_ready, a_resp_valid, a_err, a_busy;
  logic [15:0] a_rdata;

  logic        b_valid, b_write;
  logic [15:0] b_addr, b_wdata;
  logic        b_ready, b_resp_valid, b_err, b_busy;
  logic [15:0] b_rdata;

  int tests_run    = 0;
  int tests_failed = 0;

  // Clock and timeout
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  data_mem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(12), .WAIT_STATES(2)) dut_a (
    .clk(clk), .reset(reset),
    .req_valid(a_valid), .req_ready(a_ready), .req_write(a_write),
    .req_addr(a_addr), .req_wdata(a_wdata),
    .resp_valid(a_resp_valid), .resp_rdata(a_rdata), .resp_err(a_err),
    .busy(a_busy)
  );

  data_mem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(12), .WAIT_STATES(0)) dut_b (
    .clk(clk), .reset(reset),
    .req_valid(b_valid), .req_ready(b_ready), .req_write(b_write),
    .req_addr(b_addr), .req_wdata(b_wdata),
    .resp_valid(b_resp_valid), .resp_rdata(b_rdata), .resp_err(b_err),
    .busy(b_busy)
  );

  // Driver and check tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Runs one full transaction on dut_a. It starts in an IDLE cycle and
  // returns in the next IDLE cycle, which is cycle 4.
  task automatic txn_a(input string tag, input logic wr, input logic [15:0] addr,
                       input logic [15:0] wdata, input logic exp_err,
                       input logic [15:0] exp_rdata);
    check({tag, " c0 ready"}, a_ready, 1);
    a_valid = 1'b1; a_write = wr; a_addr = addr; a_wdata = wdata;
    step();
    a_valid = 1'b0; a_write = 1'b0; a_addr = 16'hFFFF; a_wdata = 16'hDEAD;
    check({tag, " c1 ready"}, a_ready, 0);
    check({tag, " c1 busy"}, a_busy, 1);
    check({tag, " c1 resp_valid"}, a_resp_valid, 0);
    step();
    check({tag, " c2 resp_valid"}, a_resp_valid, 0);
    step();
    check({tag, " c3 resp_valid"}, a_resp_valid, 1);
    check({tag, " c3 err"}, a_err, exp_err);
    check({tag, " c3 rdata"}, a_rdata, exp_rdata);
    check({tag, " c3 ready"}, a_ready, 0);
    step();
    check({tag, " c4 resp_valid"}, a_resp_valid, 0);
    check({tag, " c4 rdata"}, a_rdata, 0);
    check({tag, " c4 err"}, a_err, 0);
    check({tag, " c4 busy"}, a_busy, 0);
  endtask

  // Directed sequence
  initial begin
    reset = 1'b0;
    a_valid = 1'b0; a_write = 1'b0; a_addr = '0; a_wdata = '0;
    b_valid = 1'b0; b_write = 1'b0; b_addr = '0; b_wdata = '0;

    // Reset and idle
    step(); step();
    check("rst ready", a_ready, 1);
    check("rst resp_valid", a_resp_valid, 0);
    check("rst busy", a_busy, 0);
    reset = 1'b1;
    step();
    check("post-rst ready", a_ready, 1);
    check("post-rst busy", a_busy, 0);
    check("post-rst b ready", b_ready, 1);
    for (int i = 0; i < 10; i++) begin
      check("idle resp_valid", a_resp_valid, 0);
      step();
    end

    // Store then load
    txn_a("st 0010", 1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0000);
    txn_a("ld 0010", 1'b0, 16'h0010, 16'h0000, 1'b0, 16'hBEEF);

    // Back-to-back loads with req_valid held
    txn_a("st 0001", 1'b1, 16'h0001, 16'h0101, 1'b0, 16'h0000);
    txn_a("st 0002", 1'b1, 16'h0002, 16'h0202, 1'b0, 16'h0000);
    check("b2b c0 ready", a_ready, 1);
    a_valid = 1'b1; a_write = 1'b0; a_addr = 16'h0001;
    step();
    // The address changes during WAIT. The change must not disturb the
    // load of 0x0001.
    a_addr = 16'h0002;
    check("b2b c1 ready", a_ready, 0);
    step();
    check("b2b c2 ready", a_ready, 0);
    step();
    check("b2b c3 ready", a_ready, 0);
    check("b2b c3 resp_valid", a_resp_valid, 1);
    check("b2b c3 rdata", a_rdata, 16'h0101);
    step();
    check("b2b c4 ready", a_ready, 1);
    check("b2b c4 resp_valid", a_resp_valid, 0);
    step();
    a_valid = 1'b0;
    check("b2b c5 ready", a_ready, 0);
    step();
    check("b2b c6 resp_valid", a_resp_valid, 0);
    step();
    check("b2b c7 resp_valid", a_resp_valid, 1);
    check("b2b c7 rdata", a_rdata, 16'h0202);
    step();
    check("b2b c8 ready", a_ready, 1);

    // Out of range. 0x1000 would alias onto 0x0000 if the high bits were
    // dropped.
    txn_a("st 0000", 1'b1, 16'h0000, 16'h0A0A, 1'b0, 16'h0000);
    txn_a("st 1000 oor", 1'b1, 16'h1000, 16'h1234, 1'b1, 16'h0000);
    txn_a("ld 0000", 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0A0A);
    txn_a("ld 8000 oor", 1'b0, 16'h8000, 16'h0000, 1'b1, 16'h0000);

    // Reset during the first WAIT cycle aborts the store
    txn_a("st 0020", 1'b1, 16'h0020, 16'h1111, 1'b0, 16'h0000);
    a_valid = 1'b1; a_write = 1'b1; a_addr = 16'h0020; a_wdata = 16'h5555;
    step();
    a_valid = 1'b0;
    check("abort c1 busy", a_busy, 1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("abort ready", a_ready, 1);
    check("abort busy", a_busy, 0);
    for (int i = 0; i < 4; i++) begin
      check("abort resp_valid", a_resp_valid, 0);
      step();
    end
    txn_a("ld 0020", 1'b0, 16'h0020, 16'h0000, 1'b0, 16'h1111);

    // Zero-wait build: store, then load held back-to-back
    check("ws0 c0 ready", b_ready, 1);
    b_valid = 1'b1; b_write = 1'b1; b_addr = 16'h0003; b_wdata = 16'h3333;
    step();
    check("ws0 c1 resp_valid", b_resp_valid, 1);
    check("ws0 c1 ready", b_ready, 0);
    check("ws0 c1 rdata", b_rdata, 16'h0000);
    b_write = 1'b0;
    step();
    check("ws0 c2 ready", b_ready, 1);
    check("ws0 c2 resp_valid", b_resp_valid, 0);
    step();
    b_valid = 1'b0;
    check("ws0 c3 resp_valid", b_resp_valid, 1);
    check("ws0 c3 rdata", b_rdata, 16'h3333);
    check("ws0 c3 err", b_err, 0);
    step();
    check("ws0 c4 resp_valid", b_resp_valid, 0);
    check("ws0 c4 busy", b_busy, 0);

    // Report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
